// File: rtl/shift_pkg.sv
// Shared constants and state type for the universal shift register.
package shift_pkg;

    localparam logic [1:0] MODE_SERIAL = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_ARITH  = 2'b10;
    localparam logic [1:0] MODE_ZERO   = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift of a WIDTH-bit word with selectable fill bit.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic             data,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit
);

    logic fill;

    // Pick the departing bit, the fill bit for the vacated end, and form the shifted word.
    always_comb begin
        out_bit = direction ? cur[WIDTH-1] : cur[0];
        fill    = 1'b0;
        case (mode)
            MODE_SERIAL: fill = data;
            MODE_ROTATE: fill = out_bit;
            MODE_ARITH:  fill = direction ? 1'b0 : cur[WIDTH-1];
            default:     fill = 1'b0;
        endcase
        if (direction) begin
            nxt = {cur[WIDTH-2:0], fill};
        end else begin
            nxt = {fill, cur[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: parallel load, single-step shift and multi-step runs.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             data,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic             pload,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [1:0]       mode_q;

    logic             step_dir;
    logic [1:0]       step_mode;
    logic [WIDTH-1:0] step_nxt;
    logic             step_bit;

    // A run uses the direction/mode latched at start; single-step load uses live inputs.
    assign step_dir  = (state == S_RUN) ? dir_q  : direction;
    assign step_mode = (state == S_RUN) ? mode_q : mode;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur      (out),
        .direction(step_dir),
        .mode     (step_mode),
        .data     (data),
        .nxt      (step_nxt),
        .out_bit  (step_bit)
    );

    // Control FSM with counter; out, sout, busy and done are all registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            dir_q  <= 1'b0;
            mode_q <= MODE_SERIAL;
            out    <= '0;
            sout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pload) begin
                        out <= pdata;
                    end else if (start) begin
                        if (amount == '0) begin
                            done <= 1'b1;
                        end else begin
                            dir_q  <= direction;
                            mode_q <= mode;
                            cnt    <= amount;
                            busy   <= 1'b1;
                            state  <= S_RUN;
                        end
                    end else if (load) begin
                        out  <= step_nxt;
                        sout <= step_bit;
                    end
                end
                S_RUN: begin
                    out  <= step_nxt;
                    sout <= step_bit;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
